// File: rtl/module_temporizador_multi_if.sv
// ----------------------------------------------------------------------------
// module_temporizador_multi_if
//   Control/status bundle of the multi-channel programmable timer.
//   master : the controller; drives the enable, term-write and per-channel
//            strobes, and reads the fin/busy/flag/irq status.
//   slave  : the timer itself.
//   Signals
//     en_i       global count enable (0 freezes every counter)
//     wr_en_i    write strobe for a channel's terminal count
//     wr_ch_i    channel addressed by the write
//     wr_data_i  terminal-count value to write
//     start_i    per-channel start / retrigger strobe
//     stop_i     per-channel stop strobe
//     mode_i     per-channel mode, sampled at start (0 one-shot, 1 periodic)
//     clr_i      per-channel sticky-flag clear
//     fin_o      per-channel one-cycle terminal pulse
//     busy_o     per-channel running status
//     flag_o     per-channel sticky done flag
//     irq_o      OR of all done flags
// ----------------------------------------------------------------------------
interface module_temporizador_multi_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             en_i;
    logic             wr_en_i;
    logic [CH_W-1:0]  wr_ch_i;
    logic [CNT_W-1:0] wr_data_i;
    logic [N_CH-1:0]  start_i;
    logic [N_CH-1:0]  stop_i;
    logic [N_CH-1:0]  mode_i;
    logic [N_CH-1:0]  clr_i;
    logic [N_CH-1:0]  fin_o;
    logic [N_CH-1:0]  busy_o;
    logic [N_CH-1:0]  flag_o;
    logic             irq_o;

    modport master (
        output en_i, wr_en_i, wr_ch_i, wr_data_i, start_i, stop_i, mode_i, clr_i,
        input  fin_o, busy_o, flag_o, irq_o
    );

    modport slave (
        input  en_i, wr_en_i, wr_ch_i, wr_data_i, start_i, stop_i, mode_i, clr_i,
        output fin_o, busy_o, flag_o, irq_o
    );
endinterface

// File: rtl/module_temporizador_multi.sv
// ----------------------------------------------------------------------------
// module_temporizador_multi
//   N-channel programmable timer. Each channel counts enabled cycles up to its
//   latched terminal count, pulses fin for one cycle, and either stops
//   (one-shot) or reloads and keeps going (periodic). A sticky per-channel flag
//   records completions; irq is the OR of all flags.
//   Ports
//     clk_i  system clock, rising edge
//     rst_i  asynchronous, active-low reset
//     bus    control/status bundle (slave side), see module_temporizador_multi_if
// ----------------------------------------------------------------------------
module module_temporizador_multi #(
    parameter int unsigned      N_CH     = 4,
    parameter int unsigned      CNT_W    = 32,
    parameter logic [CNT_W-1:0] DEF_TERM = CNT_W'(99_999_999)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    module_temporizador_multi_if.slave bus
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q    [N_CH];
    logic [CNT_W-1:0] count_q    [N_CH];
    logic [CNT_W-1:0] term_q     [N_CH];
    logic [CNT_W-1:0] term_act_q [N_CH];
    logic [N_CH-1:0]  mode_act_q;
    logic [N_CH-1:0]  fin_q;
    logic [N_CH-1:0]  flag_q;
    logic [N_CH-1:0]  hit;

    // Terminal cycle of a channel; start or stop in the same cycle suppresses it.
    always_comb begin
        hit = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            hit[c] = !bus.stop_i[c] && !bus.start_i[c] && (state_q[c] == StRun) &&
                     bus.en_i && (count_q[c] == term_act_q[c]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                state_q[c]    <= StIdle;
                count_q[c]    <= '0;
                term_q[c]     <= DEF_TERM;
                term_act_q[c] <= DEF_TERM;
            end
            mode_act_q <= '0;
            fin_q      <= '0;
            flag_q     <= '0;
        end else begin
            fin_q  <= hit;
            // Set has priority over clear.
            flag_q <= hit | (flag_q & ~bus.clr_i);
            for (int unsigned c = 0; c < N_CH; c++) begin
                // Out-of-range channel numbers match no c and are dropped.
                if (bus.wr_en_i && (bus.wr_ch_i == CH_W'(c))) begin
                    term_q[c] <= bus.wr_data_i;
                end
                if (bus.stop_i[c]) begin
                    state_q[c] <= StIdle;
                    count_q[c] <= '0;
                end else if (bus.start_i[c]) begin
                    // Start from idle and retrigger while running are the same action.
                    state_q[c]    <= StRun;
                    count_q[c]    <= '0;
                    term_act_q[c] <= term_q[c];
                    mode_act_q[c] <= bus.mode_i[c];
                end else if ((state_q[c] == StRun) && bus.en_i) begin
                    if (count_q[c] == term_act_q[c]) begin
                        count_q[c] <= '0;
                        if (mode_act_q[c]) begin
                            term_act_q[c] <= term_q[c];
                        end else begin
                            state_q[c] <= StIdle;
                        end
                    end else begin
                        count_q[c] <= count_q[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.busy_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            bus.busy_o[c] = (state_q[c] == StRun);
        end
    end

    assign bus.fin_o  = fin_q;
    assign bus.flag_o = flag_q;
    assign bus.irq_o  = |flag_q;
endmodule
